// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: sample RAM geometry defaults
// and the dump FSM state encoding.
package la_pkg;

    localparam int unsigned DEF_ENTRIES = 384;
    localparam int unsigned DEF_LOG2    = 9;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRd       = 3'd1,
        StRdWait   = 3'd2,
        StSend     = 3'd3,
        StWaitSent = 3'd4,
        StDone     = 3'd5
    } dump_state_t;

endpackage

// File: rtl/chan_dump.sv
// Streams a finished capture out of the circular sample RAM, oldest sample first,
// one byte per UART transaction.
module chan_dump
    import la_pkg::*;
#(
    parameter int unsigned ENTRIES = DEF_ENTRIES,
    parameter int unsigned LOG2    = DEF_LOG2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dump_start,
    input  logic [LOG2-1:0] start_addr,
    output logic            ren,
    output logic [LOG2-1:0] raddr,
    input  logic [7:0]      rdata,
    output logic [7:0]      resp_data,
    output logic            send_resp,
    input  logic            resp_sent,
    output logic            dumping,
    output logic            dump_done
);

    // Widened so the legality check still works when ENTRIES == 2**LOG2.
    localparam logic [LOG2:0]   EntriesW = (LOG2 + 1)'(ENTRIES);
    localparam logic [LOG2-1:0] LastIdx  = LOG2'(ENTRIES - 1);
    localparam logic [LOG2-1:0] One      = LOG2'(1);

    dump_state_t     state_q, state_d;
    logic [LOG2-1:0] raddr_q, raddr_d;
    logic [LOG2-1:0] rd_cnt_q, rd_cnt_d;
    logic [7:0]      resp_data_q, resp_data_d;
    logic            dumping_q, dumping_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            raddr_q     <= '0;
            rd_cnt_q    <= '0;
            resp_data_q <= '0;
            dumping_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            rd_cnt_q    <= rd_cnt_d;
            resp_data_q <= resp_data_d;
            dumping_q   <= dumping_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        rd_cnt_d    = rd_cnt_q;
        resp_data_d = resp_data_q;
        dumping_d   = dumping_q;

        unique case (state_q)
            StIdle: begin
                if (dump_start) begin
                    // An out-of-range start address falls back to the first entry.
                    raddr_d   = ({1'b0, start_addr} >= EntriesW) ? '0 : start_addr;
                    rd_cnt_d  = '0;
                    dumping_d = 1'b1;
                    state_d   = StRd;
                end
            end
            StRd: begin
                state_d = StRdWait;
            end
            StRdWait: begin
                resp_data_d = rdata;
                state_d     = StSend;
            end
            StSend: begin
                state_d = StWaitSent;
            end
            StWaitSent: begin
                if (resp_sent) begin
                    if (rd_cnt_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        rd_cnt_d = rd_cnt_q + One;
                        raddr_d  = (raddr_q == LastIdx) ? '0 : raddr_q + One;
                        state_d  = StRd;
                    end
                end
            end
            StDone: begin
                dumping_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                dumping_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    assign ren       = (state_q == StRd);
    assign send_resp = (state_q == StSend);
    assign dump_done = (state_q == StDone);
    assign raddr     = raddr_q;
    assign resp_data = resp_data_q;
    assign dumping   = dumping_q;

endmodule

// File: tb/tb_chan_dump.sv
// Bench for chan_dump: RAM and UART models around the DUT, scoreboard of expected
// (address, byte) pairs per dump, plus reset-mid-dump and spurious-ack sequences.
module tb_chan_dump;
    import la_pkg::*;

    localparam int unsigned ENTRIES = 384;
    localparam int unsigned LOG2    = 9;
    localparam int unsigned ACK_DLY = 10;
    localparam int unsigned BUDGET  = ENTRIES * 25;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            dump_start = 1'b0;
    logic [LOG2-1:0] start_addr = '0;
    logic            ren;
    logic [LOG2-1:0] raddr;
    logic [7:0]      rdata = '0;
    logic [7:0]      resp_data;
    logic            send_resp;
    logic            resp_sent = 1'b0;
    logic            dumping;
    logic            dump_done;

    chan_dump #(
        .ENTRIES(ENTRIES),
        .LOG2   (LOG2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dump_start(dump_start),
        .start_addr(start_addr),
        .ren       (ren),
        .raddr     (raddr),
        .rdata     (rdata),
        .resp_data (resp_data),
        .send_resp (send_resp),
        .resp_sent (resp_sent),
        .dumping   (dumping),
        .dump_done (dump_done)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [ENTRIES];
    initial for (int i = 0; i < ENTRIES; i++) ram[i] = 8'(i);

    // One-cycle read latency RAM.
    always @(posedge clk) if (ren) rdata <= (raddr < LOG2'(ENTRIES)) ? ram[raddr] : 8'hxx;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    typedef struct {
        logic [LOG2-1:0] addr;
        logic [7:0]      data;
    } exp_t;
    exp_t exp_q[$];

    int   sent_cnt = 0;
    int   read_cnt = 0;
    int   done_cnt = 0;
    bit   prev_send = 1'b0;
    bit   spurious_mode = 1'b0;
    logic [7:0] held_data;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ren) begin
                if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
                else chk("raddr", 32'(raddr), 32'(exp_q[0].addr));
                read_cnt++;
            end
            if (send_resp) begin
                chk("send_resp_single_clk", 32'(prev_send), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_send", 1, 0);
                end else begin
                    chk("resp_data", 32'(resp_data), 32'(exp_q[0].data));
                    void'(exp_q.pop_front());
                end
                sent_cnt++;
            end
            if (dump_done) begin
                chk("dumping_at_done", 32'(dumping), 1);
                done_cnt++;
            end
            prev_send = send_resp;
        end else begin
            prev_send = 1'b0;
        end
    end

    // UART model: ack ACK_DLY clocks after send_resp; in spurious mode the ack is
    // stretched over the following RD and RD_WAIT cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && send_resp) begin
                held_data = resp_data;
                repeat (ACK_DLY) @(posedge clk);
                #1;
                if (rst_n) chk("resp_data_stable", 32'(resp_data), 32'(held_data));
                resp_sent = 1'b1;
                repeat (spurious_mode ? 3 : 1) @(posedge clk);
                #1 resp_sent = 1'b0;
            end
        end
    end

    task automatic load_expect(input logic [LOG2-1:0] first);
        exp_q.delete();
        for (int i = 0; i < ENTRIES; i++) begin
            exp_t e;
            int unsigned a;
            a = (int'(first) + i) % ENTRIES;
            e.addr = LOG2'(a);
            e.data = ram[a];
            exp_q.push_back(e);
        end
        sent_cnt = 0;
        read_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [LOG2-1:0] sa);
        @(posedge clk);
        #1 start_addr = sa;
        dump_start = 1'b1;
        @(posedge clk);
        #1 dump_start = 1'b0;
        start_addr = LOG2'($urandom_range(0, ENTRIES - 1));
    endtask

    task automatic run_dump(input string name, input logic [LOG2-1:0] sa,
                            input logic [LOG2-1:0] first, input bit restart, input bit spur);
        int n;
        spurious_mode = spur;
        load_expect(first);
        pulse_start(sa);
        chk({name, "_dumping_high"}, 32'(dumping), 1);
        n = 0;
        fork
            begin
                if (restart) begin
                    repeat (60) @(posedge clk);
                    #1 start_addr = LOG2'(ENTRIES / 2);
                    dump_start = 1'b1;
                    @(posedge clk);
                    #1 dump_start = 1'b0;
                end
            end
            begin
                while (done_cnt == 0 && n < BUDGET) begin
                    @(posedge clk);
                    n++;
                end
            end
        join
        chk({name, "_done_seen"}, 32'(done_cnt != 0), 1);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_done_count"}, 32'(done_cnt), 1);
        chk({name, "_bytes_sent"}, 32'(sent_cnt), ENTRIES);
        chk({name, "_reads"}, 32'(read_cnt), ENTRIES);
        chk({name, "_scoreboard_empty"}, 32'(exp_q.size()), 0);
        chk({name, "_dumping_low"}, 32'(dumping), 0);
        chk({name, "_idle_no_ren"}, 32'(ren), 0);
        spurious_mode = 1'b0;
    endtask

    typedef struct {
        string           name;
        logic [LOG2-1:0] sa;
        logic [LOG2-1:0] first;
        bit              restart;
        bit              spur;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{"start0",    9'd0,   9'd0,   1'b0, 1'b0};
        vecs[1] = '{"start380",  9'd380, 9'd380, 1'b0, 1'b0};
        vecs[2] = '{"start383",  9'd383, 9'd383, 1'b0, 1'b0};
        vecs[3] = '{"restart",   9'd200, 9'd200, 1'b1, 1'b0};
        vecs[4] = '{"spurious",  9'd17,  9'd17,  1'b0, 1'b1};
        vecs[5] = '{"illegal",   9'd450, 9'd0,   1'b0, 1'b0};

        #3 rst_n = 1'b0;
        #1;
        chk("rst_ren", 32'(ren), 0);
        chk("rst_send_resp", 32'(send_resp), 0);
        chk("rst_dump_done", 32'(dump_done), 0);
        chk("rst_dumping", 32'(dumping), 0);
        chk("rst_raddr", 32'(raddr), 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_dump(vecs[i].name, vecs[i].sa, vecs[i].first, vecs[i].restart, vecs[i].spur);

        // Reset while waiting for the 100th byte's ack.
        load_expect(9'd0);
        pulse_start(9'd0);
        n = 0;
        while (sent_cnt < 100 && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        chk("midreset_reached_byte100", 32'(sent_cnt), 100);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_ren", 32'(ren), 0);
        chk("midreset_send_resp", 32'(send_resp), 0);
        chk("midreset_dump_done", 32'(dump_done), 0);
        chk("midreset_dumping", 32'(dumping), 0);
        chk("midreset_raddr", 32'(raddr), 0);
        chk("midreset_resp_data", 32'(resp_data), 0);
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_no_done", 32'(done_cnt), 0);
        chk("midreset_stays_idle", 32'(dumping), 0);
        run_dump("after_reset", 9'd5, 9'd5, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
